// File: rtl/uc_seq_pkg.sv
// Shared types and constants for the timing/instruction-state sequencer.
package uc_seq_pkg;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    localparam logic [3:0] T_LAST = 4'hF;
    localparam int         OPC_HI = 7;
    localparam int         OPC_LO = 4;
endpackage

// File: rtl/uc_tstate_counter.sv
// 4-bit timing-state counter with enable, synchronous clear and terminal-count flag.
module uc_tstate_counter
    import uc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [3:0] t_o,
    output logic       tc_o
);
    logic [3:0] t_q, t_d;

    always_comb begin
        t_d = t_q;
        if (en_i) t_d = clr_i ? 4'd0 : t_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) t_q <= 4'd0;
        else     t_q <= t_d;
    end

    assign t_o  = t_q;
    assign tc_o = (t_q == T_LAST);
endmodule

// File: rtl/uc_sequencer.sv
// Timing/instruction-state sequencer: T counter, IR, C/Z flags, run/halt/fault control.
// Optional single-step support is compiled in with UC_SINGLE_STEP_EN.
module uc_sequencer
    import uc_seq_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       mbr,
    input  logic             ir_load,
    input  logic             t_clr,
    input  logic             flag_load,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             run_req,
`ifdef UC_SINGLE_STEP_EN
    input  logic             step_req,
`endif
    output logic [3:0]       t,
    output logic [3:0]       q,
    output logic [7:0]       ir,
    output logic             c,
    output logic             z,
    output logic             step_en,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam state_e ST_RESET = RESET_RUN ? ST_RUN : ST_HALTED;

    state_e           state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic [7:0]       ir_q;
    logic             c_q, z_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tc, boundary, fault_trip, t_en;

    assign step_en    = (state_q == ST_RUN) && mem_ready;
    assign boundary   = step_en && t_clr;
    assign fault_trip = step_en && tc && !t_clr;
    // Freeze T at its last value on the faulting step instead of wrapping.
    assign t_en       = step_en && !fault_trip;

    uc_tstate_counter u_tcnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (t_en),
        .clr_i (t_clr),
        .t_o   (t),
        .tc_o  (tc)
    );

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q | halt_req;
        case (state_q)
            ST_RUN: begin
                if (fault_trip) begin
                    state_d = ST_FAULT;
                end else if (boundary && (halt_pend_q || halt_req)) begin
                    state_d     = ST_HALTED;
                    halt_pend_d = 1'b0;
                end
            end
            ST_HALTED: begin
`ifdef UC_SINGLE_STEP_EN
                if (step_req) begin
                    state_d     = ST_RUN;
                    halt_pend_d = 1'b1;
                end else if (run_req && !halt_req) begin
                    state_d = ST_RUN;
                end
`else
                if (run_req && !halt_req) state_d = ST_RUN;
`endif
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q  <= 8'h00;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            cnt_q <= '0;
        end else if (step_en) begin
            if (ir_load)   ir_q <= mbr;
            if (flag_load) begin
                c_q <= alu_c;
                z_q <= alu_z;
            end
            if (t_clr)     cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ir        = ir_q;
    assign q         = ir_q[OPC_HI:OPC_LO];
    assign c         = c_q;
    assign z         = z_q;
    assign halted    = (state_q == ST_HALTED);
    assign fault     = (state_q == ST_FAULT);
    assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_uc_sequencer.sv
// Self-checking bench for uc_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_uc_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mbr = 8'h00;
    logic       ir_load = 0, t_clr = 0, flag_load = 0, alu_c = 0, alu_z = 0;
    logic       mem_ready = 1, halt_req = 0, run_req = 0, step_req = 0;

    logic [3:0]  t, q, h_t, h_q;
    logic [7:0]  ir, h_ir;
    logic        c, z, step_en, halted, fault;
    logic        h_c, h_z, h_step_en, h_halted, h_fault;
    logic [15:0] instr_cnt, h_instr_cnt;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    uc_sequencer #(.CNT_W(16), .RESET_RUN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .mbr(mbr), .ir_load(ir_load), .t_clr(t_clr),
        .flag_load(flag_load), .alu_c(alu_c), .alu_z(alu_z), .mem_ready(mem_ready),
        .halt_req(halt_req), .run_req(run_req),
`ifdef UC_SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .t(t), .q(q), .ir(ir), .c(c), .z(z), .step_en(step_en), .halted(halted),
        .fault(fault), .instr_cnt(instr_cnt)
    );

    uc_sequencer #(.CNT_W(16), .RESET_RUN(1'b0)) u_dut_h (
        .clk(clk), .rst(rst), .mbr(mbr), .ir_load(ir_load), .t_clr(t_clr),
        .flag_load(flag_load), .alu_c(alu_c), .alu_z(alu_z), .mem_ready(mem_ready),
        .halt_req(halt_req), .run_req(run_req),
`ifdef UC_SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .t(h_t), .q(h_q), .ir(h_ir), .c(h_c), .z(h_z), .step_en(h_step_en), .halted(h_halted),
        .fault(h_fault), .instr_cnt(h_instr_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = running, 1 = halted, 2 = faulted.
    int       ms, mt, mcnt;
    bit [7:0] mir;
    bit       mc, mz, mpend;

    task automatic mreset();
        ms = 0; mt = 0; mcnt = 0; mir = 8'h00; mc = 0; mz = 0; mpend = 0;
    endtask

    task automatic madvance();
        bit adv, pend;
        adv  = (ms == 0) && mem_ready;
        pend = mpend || halt_req;
        if (ms == 0 && adv) begin
            if (ir_load)   mir = mbr;
            if (flag_load) begin mc = alu_c; mz = alu_z; end
            if (t_clr) begin
                mt   = 0;
                mcnt = (mcnt + 1) % 65536;
                if (pend) begin ms = 1; pend = 0; end
            end else if (mt == 15) ms = 2;
            else mt = mt + 1;
        end else if (ms == 1) begin
`ifdef UC_SINGLE_STEP_EN
            if (step_req) begin ms = 0; pend = 1; end
            else if (run_req && !halt_req) ms = 0;
`else
            if (run_req && !halt_req) ms = 0;
`endif
        end
        mpend = pend;
    endtask

    always @(negedge clk) begin
        if (rst) mreset();
        else begin
            chk("t", t, mt[3:0]);
            chk("ir", ir, mir);
            chk("q", q, mir[7:4]);
            chk("c", c, mc);
            chk("z", z, mz);
            chk("halted", halted, ms == 1);
            chk("fault", fault, ms == 2);
            chk("instr_cnt", instr_cnt, mcnt);
            chk("step_en", step_en, (ms == 0) && mem_ready);
            madvance();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 0;
        chk("rst_t", t, 0);
        chk("rst_ir", ir, 0);
        chk("rst_cnt", instr_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_step_en", step_en, 1);
        chk("rst0_halted", h_halted, 1);
        chk("rst0_step_en", h_step_en, 0);

        tick(); chk("count1", t, 1);
        tick(); chk("count2", t, 2);
        mbr = 8'hA5; ir_load = 1;
        tick(); chk("ir_A5", ir, 8'hA5); chk("q_A", q, 4'hA); chk("count3", t, 3);
        ir_load = 0; flag_load = 1; alu_c = 1; alu_z = 0;
        tick(); chk("c_set", c, 1); chk("z_clr", z, 0);
        flag_load = 0; alu_c = 0; alu_z = 1;
        mem_ready = 0; ir_load = 1; mbr = 8'h11;
        #1 chk("stall_step_en", step_en, 0);
        repeat (3) tick();
        chk("stall_t", t, 4); chk("stall_ir", ir, 8'hA5);
        mem_ready = 1; ir_load = 0;
        tick(); chk("resume_t", t, 5); chk("c_hold", c, 1); chk("z_hold", z, 0);
        t_clr = 1;
        tick(); chk("clr_t", t, 0); chk("cnt1", instr_cnt, 1);
        t_clr = 0;

        repeat (3) tick();
        halt_req = 1; tick(); halt_req = 0;
        tick(); tick(); chk("pre_halt_t", t, 6);
        t_clr = 1;
        tick(); chk("halt_cnt", instr_cnt, 2); chk("halt_t", t, 0);
        chk("halted", halted, 1); chk("halt_step_en", step_en, 0);
        t_clr = 0;
        tick(); chk("halt_hold", halted, 1); chk("halt_t0", t, 0);
        run_req = 1;
        tick(); chk("run_halted", halted, 0); chk("run_step_en", step_en, 1);
        run_req = 0;
        tick(); chk("run_t1", t, 1);

`ifdef UC_SINGLE_STEP_EN
        halt_req = 1; tick(); halt_req = 0;
        t_clr = 1; tick(); t_clr = 0;
        chk("ss_halted", halted, 1); chk("ss_cnt", instr_cnt, 3);
        step_req = 1; tick(); step_req = 0;
        chk("ss_run", halted, 0);
        tick(); tick();
        t_clr = 1; tick(); t_clr = 0;
        chk("ss_rehalt", halted, 1); chk("ss_cnt2", instr_cnt, 4);
        run_req = 1; tick(); run_req = 0;
`else
        t_clr = 1; tick(); t_clr = 0;
`endif
        repeat (15) tick();
        chk("pre_fault_t", t, 4'hF); chk("pre_fault", fault, 0);
        tick(); chk("fault", fault, 1); chk("fault_t", t, 4'hF); chk("fault_step_en", step_en, 0);
        tick(); chk("fault_sticky", fault, 1); chk("fault_t_hold", t, 4'hF);
        #1 rst = 1;
        #1 chk("fault_rst", fault, 0);
        @(posedge clk); #2 rst = 0;

        repeat (15) tick();
        t_clr = 1;
        tick(); chk("tF_clr_t", t, 0); chk("tF_clr_fault", fault, 0);
        t_clr = 0;

        mbr = 8'h3C; ir_load = 1; flag_load = 1; alu_c = 1; alu_z = 0;
        tick(); ir_load = 0; flag_load = 0;
        repeat (6) tick();
        chk("mid_t", t, 7); chk("mid_ir", ir, 8'h3C); chk("mid_c", c, 1);
        #1 rst = 1;
        #1;
        chk("arst_t", t, 0); chk("arst_ir", ir, 0); chk("arst_q", q, 0);
        chk("arst_c", c, 0); chk("arst_cnt", instr_cnt, 0); chk("arst_halted", halted, 0);
        @(posedge clk); #2 rst = 0;

        for (int seg = 0; seg < 6; seg++) begin
            int clr_mod;
            clr_mod = (seg % 2 == 0) ? 3 : 7;
            for (int n = 0; n < 300; n++) begin
                mbr       = 8'($urandom);
                ir_load   = ($urandom % 4) == 0;
                flag_load = ($urandom % 4) == 0;
                alu_c     = $urandom % 2;
                alu_z     = $urandom % 2;
                t_clr     = ($urandom % clr_mod) == 0;
                mem_ready = ($urandom % 5) != 0;
                halt_req  = ($urandom % 16) == 0;
                run_req   = ($urandom % 4) == 0;
                step_req  = ($urandom % 8) == 0;
                tick();
            end
            rst = 1;
            tick();
            rst = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
